// File: rtl/vgpr_wr_arbiter.sv
// VGPR write-port arbiter: one registered one-hot grant per cycle among 8 ALU
// write-backs (round-robin) and the LSU (priority, bounded by a burst limit).
module vgpr_wr_arbiter #(
  parameter int unsigned LSU_MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        simd0_wr_req,
  input  logic        simd1_wr_req,
  input  logic        simd2_wr_req,
  input  logic        simd3_wr_req,
  input  logic        simf0_wr_req,
  input  logic        simf1_wr_req,
  input  logic        simf2_wr_req,
  input  logic        simf3_wr_req,
  input  logic        lsu_wr_req,
  output logic [15:0] rfa_select_fu,
  output logic        rfa_grant_valid,
  output logic [3:0]  rfa_lsu_burst_cnt
);

  localparam int unsigned N_ALU  = 8;
  localparam int unsigned N_REQ  = 9;
  localparam int unsigned SEL_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned LSU_IX = 8;

  logic [SEL_W-1:0] r_sel;
  logic             r_grant_valid;
  logic [CNT_W-1:0] r_burst;
  logic [PTR_W-1:0] r_rr_ptr;

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_elig;
  logic             w_alu_elig;
  logic             w_alu_pending;
  logic             w_lsu_elig;
  logic             w_alu_found;
  logic [PTR_W-1:0] w_alu_idx;
  logic [PTR_W-1:0] w_cand;
  logic [SEL_W-1:0] w_next_sel;
  logic [CNT_W-1:0] w_next_burst;
  logic [PTR_W-1:0] w_next_rr;

  assign w_req = {lsu_wr_req,
                  simf3_wr_req, simf2_wr_req, simf1_wr_req, simf0_wr_req,
                  simd3_wr_req, simd2_wr_req, simd1_wr_req, simd0_wr_req};

  // ALU requesters granted this cycle are masked so a late-dropped request is
  // not granted twice; the LSU is a streaming source and may be granted back to back.
  assign w_elig        = {w_req[LSU_IX], w_req[N_ALU-1:0] & ~r_sel[N_ALU-1:0]};
  assign w_alu_elig    = |w_elig[N_ALU-1:0];
  assign w_alu_pending = |w_req[N_ALU-1:0];
  assign w_lsu_elig    = w_elig[LSU_IX];

  // Round-robin search over ALU requesters starting at r_rr_ptr.
  always_comb begin
    w_alu_found = 1'b0;
    w_alu_idx   = '0;
    w_cand      = '0;
    for (int i = 0; i < int'(N_ALU); i++) begin
      w_cand = r_rr_ptr + PTR_W'(i);
      if (!w_alu_found && w_elig[w_cand]) begin
        w_alu_found = 1'b1;
        w_alu_idx   = w_cand;
      end
    end
  end

  // Grant selection, pointer and burst-counter update.
  always_comb begin
    w_next_sel   = '0;
    w_next_rr    = r_rr_ptr;
    w_next_burst = r_burst;
    if (w_lsu_elig && (!w_alu_elig || (r_burst < CNT_W'(LSU_MAX_BURST)))) begin
      w_next_sel[LSU_IX] = 1'b1;
      if (w_alu_pending && (r_burst != {CNT_W{1'b1}})) begin
        w_next_burst = r_burst + CNT_W'(1);
      end
    end else if (w_alu_found) begin
      w_next_sel[w_alu_idx] = 1'b1;
      w_next_rr             = w_alu_idx + PTR_W'(1);
      w_next_burst          = '0;
    end else begin
      w_next_burst = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel         <= '0;
      r_grant_valid <= 1'b0;
      r_burst       <= '0;
      r_rr_ptr      <= '0;
    end else begin
      r_sel         <= w_next_sel;
      r_grant_valid <= |w_next_sel;
      r_burst       <= w_next_burst;
      r_rr_ptr      <= w_next_rr;
    end
  end

  assign rfa_select_fu     = r_sel;
  assign rfa_grant_valid   = r_grant_valid;
  assign rfa_lsu_burst_cnt = r_burst;

endmodule

// File: tb/tb_vgpr_wr_arbiter.sv
// Directed bench for vgpr_wr_arbiter with hand-computed expected grants.
module tb_vgpr_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  req;
  logic [15:0] rfa_select_fu;
  logic        rfa_grant_valid;
  logic [3:0]  rfa_lsu_burst_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vgpr_wr_arbiter #(.LSU_MAX_BURST(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .simd0_wr_req     (req[0]),
    .simd1_wr_req     (req[1]),
    .simd2_wr_req     (req[2]),
    .simd3_wr_req     (req[3]),
    .simf0_wr_req     (req[4]),
    .simf1_wr_req     (req[5]),
    .simf2_wr_req     (req[6]),
    .simf3_wr_req     (req[7]),
    .lsu_wr_req       (req[8]),
    .rfa_select_fu    (rfa_select_fu),
    .rfa_grant_valid  (rfa_grant_valid),
    .rfa_lsu_burst_cnt(rfa_lsu_burst_cnt)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_sel;
    logic [15:0] one;
    rst = 1'b1;
    req = '0;

    do_reset();
    check_eq("reset_sel", rfa_select_fu, 16'h0000);
    check_eq("reset_gv", 16'(rfa_grant_valid), 16'h0000);
    check_eq("reset_cnt", 16'(rfa_lsu_burst_cnt), 16'h0000);

    // Single request simd2 for one cycle.
    req = 9'h004;
    step();
    check_eq("single_sel", rfa_select_fu, 16'h0004);
    check_eq("single_gv", 16'(rfa_grant_valid), 16'h0001);
    req = '0;
    step();
    check_eq("single_off", rfa_select_fu, 16'h0000);
    check_eq("single_gv_off", 16'(rfa_grant_valid), 16'h0000);

    // All ALU requests held: round-robin walk 0..7 then wrap to 0.
    do_reset();
    req = 9'h0FF;
    for (int i = 0; i < 9; i++) begin
      step();
      one = 16'h0001;
      exp_sel = one << (i % 8);
      check_eq($sformatf("rr_%0d", i), rfa_select_fu, exp_sel);
    end
    req = '0;
    step();
    check_eq("rr_idle", rfa_select_fu, 16'h0000);

    // LSU + simf1 held: four LSU grants then one simf1 grant, repeating.
    do_reset();
    req = 9'h120;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq($sformatf("burst_sel_%0d", i), rfa_select_fu, ((i % 5) == 4) ? 16'h0020 : 16'h0100);
      check_eq($sformatf("burst_cnt_%0d", i), 16'(rfa_lsu_burst_cnt), ((i % 5) == 4) ? 16'h0000 : 16'((i % 5) + 1));
    end

    // LSU alone held: granted every cycle, counter stays 0.
    do_reset();
    req = 9'h100;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq($sformatf("lsu_sel_%0d", i), rfa_select_fu, 16'h0100);
      check_eq($sformatf("lsu_cnt_%0d", i), 16'(rfa_lsu_burst_cnt), 16'h0000);
    end

    // simd0 holds req one cycle past its grant; must not be granted twice.
    do_reset();
    req = 9'h001;
    step();
    check_eq("late_drop_g0", rfa_select_fu, 16'h0001);
    req = 9'h003;
    step();
    check_eq("late_drop_g1", rfa_select_fu, 16'h0002);
    req = '0;
    step();
    check_eq("late_drop_idle", rfa_select_fu, 16'h0000);

    // Build rr_ptr=5 and burst count 3, then reset mid-burst.
    do_reset();
    req = 9'h010;
    step();
    check_eq("pre_simf0", rfa_select_fu, 16'h0010);
    req = 9'h101;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("pre_lsu_%0d", i), rfa_select_fu, 16'h0100);
      check_eq($sformatf("pre_cnt_%0d", i), 16'(rfa_lsu_burst_cnt), 16'(i + 1));
    end
    rst = 1'b1;
    req = 9'h0FF;
    step();
    check_eq("midrst_sel", rfa_select_fu, 16'h0000);
    check_eq("midrst_gv", 16'(rfa_grant_valid), 16'h0000);
    check_eq("midrst_cnt", 16'(rfa_lsu_burst_cnt), 16'h0000);
    rst = 1'b0;
    step();
    check_eq("postrst_sel", rfa_select_fu, 16'h0001);
    check_eq("postrst_gv", 16'(rfa_grant_valid), 16'h0001);
    step();
    check_eq("postrst_next", rfa_select_fu, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
